// File: rtl/uart_apb_master_if.sv
// APB3 bus between uart_apb_master and the CoreUARTapb slave port.
// Carries the select/enable handshake, address/data and the slave response.
interface uart_apb_master_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_apb_master.sv
// APB3 master for CoreUARTapb: programs CTRL1/CTRL2 after reset, then moves
// bytes between valid/ready streams and TXDATA/RXDATA, paced by TXRDY/RXRDY.
module uart_apb_master #(
  parameter logic [12:0] BAUD_VAL   = 13'd1,
  parameter bit          BIT8       = 1'b1,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int          GAP_CYCLES = 2,
  parameter int          TIMEOUT    = 255
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  uart_apb_master_if.master         apb,
  input  logic                      TXRDY,
  input  logic                      RXRDY,
  input  logic                      PARITY_ERR,
  input  logic                      OVERFLOW,
  input  logic                      FRAMING_ERR,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [4:0]                err_flags,
  input  logic                      err_clr,
  output logic                      init_done
);

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [7:0] CTRL2_VAL   = {BAUD_VAL[12:8], PARITY_ODD, PARITY_EN, BIT8};

  typedef enum logic [2:0] {
    S_INIT_C1,
    S_INIT_C2,
    S_GAP,
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  typedef enum logic [1:0] {
    OP_C1,
    OP_C2,
    OP_TX,
    OP_RX
  } op_t;

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] tmo_q, tmo_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       init_done_q, init_done_d;
  logic [4:0] err_q, err_d;
  logic [4:0] err_set;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= S_INIT_C1;
      op_q        <= OP_C1;
      addr_q      <= 5'd0;
      wdata_q     <= 8'd0;
      write_q     <= 1'b0;
      gap_q       <= 4'd0;
      tmo_q       <= 8'd0;
      tx_full_q   <= 1'b0;
      tx_byte_q   <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 5'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      tx_full_q   <= tx_full_d;
      tx_byte_q   <= tx_byte_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    tx_full_d   = tx_full_q;
    tx_byte_d   = tx_byte_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    err_set     = 5'd0;

    if (tx_valid && tx_ready) begin
      tx_full_d = 1'b1;
      tx_byte_d = tx_data;
    end
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      S_INIT_C1: begin
        op_d    = OP_C1;
        addr_d  = ADDR_CTRL1;
        wdata_d = BAUD_VAL[7:0];
        write_d = 1'b1;
        state_d = S_SETUP;
      end
      S_INIT_C2: begin
        op_d    = OP_C2;
        addr_d  = ADDR_CTRL2;
        wdata_d = CTRL2_VAL;
        write_d = 1'b1;
        state_d = S_SETUP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_IDLE: begin
        // RX first: a pending UART byte is lost to overflow if left waiting
        if (RXRDY && !rx_valid_q) begin
          op_d    = OP_RX;
          addr_d  = ADDR_RXDATA;
          write_d = 1'b0;
          state_d = S_SETUP;
        end else if (tx_full_q && TXRDY) begin
          op_d    = OP_TX;
          addr_d  = ADDR_TXDATA;
          wdata_d = tx_byte_q;
          write_d = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        tmo_d   = 8'd0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (apb.PREADY) begin
          err_set[3] = apb.PSLVERR;
          gap_d      = 4'd0;
          state_d    = S_GAP;
          case (op_q)
            OP_C1:   state_d     = S_INIT_C2;
            OP_C2:   init_done_d = 1'b1;
            OP_TX:   tx_full_d   = 1'b0;
            default: begin
              rx_data_d  = apb.PRDATA;
              rx_valid_d = 1'b1;
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          // Abort: TX byte stays held for retry, init steps are reissued
          err_set[4] = 1'b1;
          gap_d      = 4'd0;
          case (op_q)
            OP_C1:   state_d = S_INIT_C1;
            OP_C2:   state_d = S_INIT_C2;
            default: state_d = S_GAP;
          endcase
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = S_INIT_C1;
    endcase

    err_set[2:0] = {FRAMING_ERR, OVERFLOW, PARITY_ERR};
    if (err_clr) begin
      err_d = 5'd0;
    end
    err_d = err_d | err_set;
  end

  // PSEL/PENABLE decode straight from state so reset drops them immediately
  assign apb.PSEL    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign apb.PENABLE = (state_q == S_ACCESS);
  assign apb.PWRITE  = write_q;
  assign apb.PADDR   = addr_q;
  assign apb.PWDATA  = wdata_q;

  assign tx_ready  = init_done_q & ~tx_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign err_flags = err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master with default parameters: init writes,
// TX/RX transfers, arbitration, error flags, timeout abort/retry and reset.
module tb_uart_apb_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       TXRDY = 1'b0, RXRDY = 1'b0;
  logic       PARITY_ERR = 1'b0, OVERFLOW = 1'b0, FRAMING_ERR = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [4:0] err_flags;
  logic       err_clr = 1'b0;
  logic       init_done;

  int vectors = 0;
  int miscompares = 0;

  uart_apb_master_if apb_bus ();

  uart_apb_master dut (
    .PCLK        (clk),
    .PRESET      (rst),
    .apb         (apb_bus),
    .TXRDY       (TXRDY),
    .RXRDY       (RXRDY),
    .PARITY_ERR  (PARITY_ERR),
    .OVERFLOW    (OVERFLOW),
    .FRAMING_ERR (FRAMING_ERR),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .err_flags   (err_flags),
    .err_clr     (err_clr),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int seen;
    apb_bus.PRDATA  = 8'h00;
    apb_bus.PREADY  = 1'b1;
    apb_bus.PSLVERR = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_apb", 32'({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PADDR, apb_bus.PWDATA}), 32'd0);
    chk("rst_ctl", 32'({tx_ready, rx_valid, init_done, err_flags}), 32'd0);
    rst = 1'b0;

    // Init: CTRL1 <= 0x01, CTRL2 <= 0x01
    tick();
    chk("c1_setup", 32'({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA}),
        32'({1'b1, 1'b0, 1'b1, 5'h08, 8'h01}));
    tick();
    chk("c1_access", 32'({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PADDR, apb_bus.PWDATA}),
        32'({1'b1, 1'b1, 5'h08, 8'h01}));
    tick();
    chk("c1_end", 32'(apb_bus.PSEL), 32'd0);
    tick();
    chk("c2_setup", 32'({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA}),
        32'({1'b1, 1'b0, 1'b1, 5'h0C, 8'h01}));
    tick();
    chk("c2_access", 32'({apb_bus.PSEL, apb_bus.PENABLE, init_done}), 32'({1'b1, 1'b1, 1'b0}));
    tick();
    chk("init_done", 32'({init_done, tx_ready, apb_bus.PSEL}), 32'({1'b1, 1'b1, 1'b0}));

    // TX 0xA5 accepted during the post-init gap, written once the gap ends
    tx_data = 8'hA5; tx_valid = 1'b1; TXRDY = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("tx_held", 32'(tx_ready), 32'd0);
    tick();
    chk("tx_gap", 32'(apb_bus.PSEL), 32'd0);
    tick();
    chk("tx_setup", 32'({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA}),
        32'({1'b1, 1'b0, 1'b1, 5'h00, 8'hA5}));
    tick();
    chk("tx_access", 32'({apb_bus.PSEL, apb_bus.PENABLE, tx_ready}), 32'({1'b1, 1'b1, 1'b0}));
    tick();
    chk("tx_done", 32'({tx_ready, apb_bus.PSEL}), 32'({1'b1, 1'b0}));
    TXRDY = 1'b0;

    // RX 0x3C, held until rx_ready
    RXRDY = 1'b1; apb_bus.PRDATA = 8'h3C;
    tick(); tick(); tick();
    chk("rx_setup", 32'({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, apb_bus.PADDR}),
        32'({1'b1, 1'b0, 1'b0, 5'h04}));
    tick();
    tick();
    chk("rx_data", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h3C}));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (apb_bus.PSEL) seen++;
    end
    chk("rx_blocked", 32'(seen), 32'd0);
    chk("rx_kept", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h3C}));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_consumed", 32'(rx_valid), 32'd0);
    tick();
    chk("rx2_setup", 32'({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PADDR}), 32'({1'b1, 1'b0, 5'h04}));
    RXRDY = 1'b0; apb_bus.PRDATA = 8'h5A;
    tick(); tick();
    chk("rx2_data", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h5A}));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();

    // Arbitration: RX before TX, write after GAP_CYCLES idle cycles; PSLVERR on write
    tx_data = 8'hC3; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    RXRDY = 1'b1; TXRDY = 1'b1; apb_bus.PRDATA = 8'h77;
    tick();
    chk("prio_rd", 32'({apb_bus.PSEL, apb_bus.PWRITE, apb_bus.PADDR}), 32'({1'b1, 1'b0, 5'h04}));
    tick(); tick();
    chk("prio_rdata", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h77}));
    RXRDY = 1'b0;
    n = 0;
    tick();
    while (!apb_bus.PSEL && n < 10) begin
      n++;
      tick();
    end
    chk("prio_gap", 32'(n), 32'd2);
    chk("prio_wr", 32'({apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA}), 32'({1'b1, 5'h00, 8'hC3}));
    apb_bus.PSLVERR = 1'b1;
    tick(); tick();
    apb_bus.PSLVERR = 1'b0;
    chk("pslverr", 32'({err_flags, tx_ready}), 32'({5'b01000, 1'b1}));
    TXRDY = 1'b0;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();

    // Sticky status flags and clear priority
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 32'(err_flags), 32'd0);
    FRAMING_ERR = 1'b1;
    tick();
    FRAMING_ERR = 1'b0;
    tick();
    chk("err_framing", 32'(err_flags), 32'(5'b00100));
    err_clr = 1'b1; PARITY_ERR = 1'b1;
    tick();
    err_clr = 1'b0; PARITY_ERR = 1'b0;
    chk("err_set_wins", 32'(err_flags), 32'(5'b00001));
    err_clr = 1'b1; OVERFLOW = 1'b1;
    tick();
    OVERFLOW = 1'b0;
    tick();
    err_clr = 1'b0;
    chk("err_overflow_clr", 32'(err_flags), 32'd0);

    // Timeout: 255 ACCESS cycles then abort, TX byte retried
    apb_bus.PREADY = 1'b0;
    tx_data = 8'hE1; tx_valid = 1'b1; TXRDY = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    chk("tmo_setup", 32'({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PADDR, apb_bus.PWDATA}),
        32'({1'b1, 1'b0, 5'h00, 8'hE1}));
    n = 0;
    tick();
    while (apb_bus.PENABLE && n < 300) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 32'(n), 32'd255);
    chk("tmo_flags", 32'({err_flags, tx_ready, apb_bus.PSEL}), 32'({5'b10000, 1'b0, 1'b0}));
    apb_bus.PREADY = 1'b1;
    n = 0;
    while (!apb_bus.PSEL && n < 10) begin
      n++;
      tick();
    end
    chk("retry_wr", 32'({apb_bus.PSEL, apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA}),
        32'({1'b1, 1'b1, 5'h00, 8'hE1}));
    tick(); tick();
    chk("retry_done", 32'(tx_ready), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_clr", 32'(err_flags), 32'd0);

    // Reset in the middle of ACCESS
    apb_bus.PREADY = 1'b0;
    tx_data = 8'h96; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_access", 32'({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWDATA}), 32'({1'b1, 1'b1, 8'h96}));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 32'({apb_bus.PSEL, apb_bus.PENABLE, tx_ready, init_done}), 32'd0);
    tick();
    rst = 1'b0;
    apb_bus.PREADY = 1'b1;
    tick();
    chk("reinit_c1", 32'({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PADDR, apb_bus.PWDATA}),
        32'({1'b1, 1'b0, 5'h08, 8'h01}));
    tick(); tick(); tick(); tick(); tick();
    chk("reinit_done", 32'({init_done, tx_ready}), 32'({1'b1, 1'b1}));
    TXRDY = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
